// File: rtl/sig_frame_pkg.sv
// Shared definitions for the framing path (feeder, Hamming window, later
// frame consumers): default frame geometry, sample width and the feeder FSM
// state encoding.
package sig_frame_pkg;

   localparam int SAMPLE_W      = 16;
   localparam int FRAME_LEN_DEF = 512;
   localparam int HOP_DEF       = 256;
   localparam int BUF_DEPTH_DEF = 1024;

   typedef enum logic [2:0] {
      ST_WAIT  = 3'd0,
      ST_INIT  = 3'd1,
      ST_RADDR = 3'd2,
      ST_PRES  = 3'd3,
      ST_DONE  = 3'd4
   } frame_state_t;

endpackage

// File: rtl/sig_frame_ram.sv
// Circular sample buffer: simple dual-port RAM, one write port and one
// registered read port. Contents are never reset; only the read register is.
module sig_frame_ram
   import sig_frame_pkg::*;
#(
   parameter int DEPTH  = BUF_DEPTH_DEF,
   parameter int DATA_W = SAMPLE_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [AW-1:0]            waddr,
   input  logic signed [DATA_W-1:0] wdata,
   input  logic                     re,
   input  logic [AW-1:0]            raddr,
   output logic signed [DATA_W-1:0] rd_data
);

   logic signed [DATA_W-1:0] mem [DEPTH];

   // Write port: store one sample per accepted write.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port: registered data, held until the next read request.
   always_ff @(posedge clk) begin
      if (rst)     rd_data <= '0;
      else if (re) rd_data <= mem[raddr];
   end

endmodule

// File: rtl/sig_frame_feeder.sv
// Producer side of the windowing sample interface. Buffers the incoming audio
// stream in a circular RAM and replays overlapping frames (FRAME_LEN samples,
// advanced by HOP), each preceded by a one-cycle win_init pulse.
// Optional feature: define SIG_PREEMPH_EN to store pre-emphasised samples
// y = x - ((PREEMPH_A * x_prev) >>> 15), saturated to the sample range.
module sig_frame_feeder
   import sig_frame_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int HOP       = HOP_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF,
`ifdef SIG_PREEMPH_EN
   parameter int PREEMPH_A = 31785,
`endif
   parameter int DATA_W    = SAMPLE_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     restart,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic                     sample_valid,
   output logic                     sample_rdy,
   output logic                     win_init,
   output logic signed [DATA_W-1:0] audio_out,
   output logic                     audio_valid,
   input  logic                     audio_rdy,
   output logic                     frame_done,
   output logic [15:0]              frame_idx
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int PW = AW + 1;
   localparam int IW = $clog2(FRAME_LEN);

   frame_state_t             state, state_nxt;
   logic [PW-1:0]            wr_ptr, frame_base, occupancy;
   logic [IW-1:0]            idx;
   logic [AW-1:0]            rd_addr;
   logic                     wr_en, rd_en, idx_clr, idx_inc, base_adv;
   logic signed [DATA_W-1:0] store_data_p0;

   // One extra pointer bit distinguishes a full buffer from an empty one.
   assign occupancy  = wr_ptr - frame_base;
   assign sample_rdy = !rst && !restart && (occupancy < PW'(BUF_DEPTH));
   assign wr_en      = sample_valid && sample_rdy;
   assign rd_addr    = frame_base[AW-1:0] + AW'(idx);

`ifdef SIG_PREEMPH_EN
   localparam logic signed [31:0] PE_COEF = 32'(PREEMPH_A);

   logic signed [DATA_W-1:0] x_prev;
   logic signed [31:0]       pe_prod_p0, pe_term_p0;

   function automatic logic signed [DATA_W-1:0] sat_sample(input logic signed [32:0] v);
      logic signed [32:0] hi, lo;
      hi = 33'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
      lo = -hi - 33'sd1;
      if (v > hi)      sat_sample = hi[DATA_W-1:0];
      else if (v < lo) sat_sample = lo[DATA_W-1:0];
      else             sat_sample = v[DATA_W-1:0];
   endfunction

   // Pre-emphasis in the write path, purely combinational so sample_rdy timing is untouched.
   always_comb begin
      pe_prod_p0    = PE_COEF * 32'(x_prev);
      pe_term_p0    = pe_prod_p0 >>> 15;
      store_data_p0 = sat_sample(33'(sample_in) - 33'(pe_term_p0));
   end

   // Previous raw sample; cleared so the first sample after (re)start passes unchanged.
   always_ff @(posedge clk) begin
      if (rst || restart) x_prev <= '0;
      else if (wr_en)     x_prev <= sample_in;
   end
`else
   assign store_data_p0 = sample_in;
`endif

   // ---- stage p0: write into buffer / issue read; p1: registered read data ----
   sig_frame_ram #(
      .DEPTH  (BUF_DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_en),
      .waddr   (wr_ptr[AW-1:0]),
      .wdata   (store_data_p0),
      .re      (rd_en),
      .raddr   (rd_addr),
      .rd_data (audio_out)
   );

   // State register; restart behaves like reset for the control path.
   always_ff @(posedge clk) begin
      if (rst || restart) state <= ST_WAIT;
      else                state <= state_nxt;
   end

   // Next-state and handshake decode.
   always_comb begin
      state_nxt   = state;
      win_init    = 1'b0;
      audio_valid = 1'b0;
      frame_done  = 1'b0;
      rd_en       = 1'b0;
      idx_clr     = 1'b0;
      idx_inc     = 1'b0;
      base_adv    = 1'b0;
      case (state)
         ST_WAIT: begin
            if (occupancy >= PW'(FRAME_LEN)) state_nxt = ST_INIT;
         end
         ST_INIT: begin
            win_init  = 1'b1;
            idx_clr   = 1'b1;
            state_nxt = ST_RADDR;
         end
         ST_RADDR: begin
            rd_en     = 1'b1;
            state_nxt = ST_PRES;
         end
         ST_PRES: begin
            audio_valid = 1'b1;
            if (audio_rdy) begin
               if (idx == IW'(FRAME_LEN - 1)) begin
                  state_nxt = ST_DONE;
               end else begin
                  idx_inc   = 1'b1;
                  state_nxt = ST_RADDR;
               end
            end
         end
         ST_DONE: begin
            frame_done = 1'b1;
            base_adv   = 1'b1;
            state_nxt  = ST_WAIT;
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   // Buffer pointers, in-frame index and completed-frame counter.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         wr_ptr     <= '0;
         frame_base <= '0;
         frame_idx  <= '0;
         idx        <= '0;
      end else begin
         if (wr_en)   wr_ptr <= wr_ptr + PW'(1);
         if (idx_clr) idx    <= '0;
         else if (idx_inc) idx <= idx + IW'(1);
         if (base_adv) begin
            frame_base <= frame_base + PW'(HOP);
            frame_idx  <= frame_idx + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_sig_frame_feeder.sv
// Bench for sig_frame_feeder: directed ramps, stall, wrap-around, restart and
// (with SIG_PREEMPH_EN) the pre-emphasis write path.
module tb_sig_frame_feeder;

   localparam int FL   = 512;
   localparam int HOP  = 256;
   localparam int MEMN = 4096;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               restart = 1'b0;
   logic signed [15:0] sample_in = '0;
   logic               sample_valid = 1'b0;
   logic               sample_rdy;
   logic               win_init;
   logic signed [15:0] audio_out;
   logic               audio_valid;
   logic               audio_rdy = 1'b1;
   logic               frame_done;
   logic [15:0]        frame_idx;

   always #5 clk = ~clk;

   sig_frame_feeder dut (
      .clk          (clk),
      .rst          (rst),
      .restart      (restart),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_rdy   (sample_rdy),
      .win_init     (win_init),
      .audio_out    (audio_out),
      .audio_valid  (audio_valid),
      .audio_rdy    (audio_rdy),
      .frame_done   (frame_done),
      .frame_idx    (frame_idx)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model state, updated on the falling edge.
   logic signed [15:0] exp_mem [MEMN];
   logic [15:0]        first_val [8];
   logic [15:0]        cap [4];
   int  in_cnt = 0, mbase = 0, midx = 0, hs_cnt = 0, win_cnt = 0, exp_fidx = 0;
   int  cyc = 0, t512 = -100;
   bit  fidx_pend = 0, first_pend = 1, av_pend = 0;

`ifdef SIG_PREEMPH_EN
   logic signed [15:0] m_prev = '0;

   function automatic logic signed [15:0] pe_model(input logic signed [15:0] x, input logic signed [15:0] xp);
      longint y;
      y = longint'(x) - ((longint'(31785) * longint'(xp)) >>> 15);
      if (y > 32767)       y = 32767;
      else if (y < -32768) y = -32768;
      return 16'(y);
   endfunction
`endif

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst || restart) begin
            in_cnt = 0; mbase = 0; midx = 0; hs_cnt = 0; win_cnt = 0; exp_fidx = 0;
            fidx_pend = 0; first_pend = 1; av_pend = 0; t512 = -100;
`ifdef SIG_PREEMPH_EN
            m_prev = '0;
`endif
         end else begin
            if (fidx_pend) begin
               check("frame_idx_after_done", 32'(frame_idx), exp_fidx & 32'hFFFF);
               fidx_pend = 0;
            end
            if (win_init) begin
               check("win_init_with_valid", 32'(audio_valid), 32'd0);
               check("frame_idx_at_init", 32'(frame_idx), exp_fidx & 32'hFFFF);
               if (win_cnt > 0) check("handshakes_between_init", hs_cnt, FL);
               if (first_pend) begin
                  check("latency_win_init", cyc - t512, 2);
                  first_pend = 0;
                  av_pend    = 1;
               end
               win_cnt++;
               hs_cnt = 0;
               midx   = 0;
            end
            if (audio_valid) begin
               if (av_pend) begin
                  check("latency_audio_valid", cyc - t512, 4);
                  av_pend = 0;
               end
               if (audio_rdy) begin
                  check("audio_out", 32'(audio_out), 32'(exp_mem[(mbase + midx) % MEMN]));
                  if (midx == 0 && exp_fidx < 8) first_val[exp_fidx] = audio_out;
                  if (exp_fidx == 0 && midx < 4) cap[midx] = audio_out;
                  midx++;
                  hs_cnt++;
               end
            end
            if (frame_done) begin
               check("frame_len", midx, FL);
               mbase += HOP;
               exp_fidx++;
               fidx_pend = 1;
            end
            if (sample_valid && sample_rdy) begin
`ifdef SIG_PREEMPH_EN
               exp_mem[in_cnt % MEMN] = pe_model(sample_in, m_prev);
               m_prev = sample_in;
`else
               exp_mem[in_cnt % MEMN] = sample_in;
`endif
               in_cnt++;
               if (in_cnt == FL) t512 = cyc;
            end
         end
      end
   end

   // Ramp source: advances only when the previous sample was accepted.
   int          feed_next = 0;
   int          feed_lim  = 0;
   bit          feed_en   = 0;
   logic [15:0] feed_off  = '0;

   initial begin
      bit acc;
      forever begin
         @(negedge clk);
         acc = sample_valid && sample_rdy;
         @(posedge clk);
         #1;
         if (acc) feed_next++;
         if (feed_en) begin
            sample_valid = (feed_next < feed_lim);
            sample_in    = feed_off + feed_next[15:0];
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; restart = 1'b0; feed_en = 0; sample_valid = 1'b0; audio_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_win_init", 32'(win_init), 32'd0);
      check("rst_audio_valid", 32'(audio_valid), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_idx", 32'(frame_idx), 32'd0);
      check("rst_audio_out", 32'(audio_out), 32'd0);
      check("rst_sample_rdy", 32'(sample_rdy), 32'd0);
      @(posedge clk);
      #1;
      feed_next = 0; feed_lim = 0; rst = 1'b0;
   endtask

   task automatic run_until_frames(input int n, input int budget, input int mode);
      int c;
      c = 0;
      while (exp_fidx < n && c < budget) begin
         @(posedge clk);
         #1;
         audio_rdy = (mode == 0) ? 1'b1 : ((c % 3) != 0);
         c++;
      end
      audio_rdy = 1'b1;
      if (exp_fidx < n) check("timeout_frames", exp_fidx, n);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [15:0] held;

   initial begin
      int c;
      // Test 1: ramp 0..1023, always ready -> three frames.
      do_reset();
      @(negedge clk);
      check("idle_sample_rdy", 32'(sample_rdy), 32'd1);
      feed_off = 16'd0; feed_lim = 1024; feed_en = 1;
      run_until_frames(3, 6000, 0);
      repeat (50) @(negedge clk);
      check("t1_frame_idx", 32'(frame_idx), 32'd3);
      check("t1_win_count", win_cnt, 3);
      check("t1_samples_in", in_cnt, 1024);
`ifndef SIG_PREEMPH_EN
      check("t1_frame0_first", 32'(first_val[0]), 32'd0);
      check("t1_frame1_first", 32'(first_val[1]), 32'd256);
      check("t1_frame2_first", 32'(first_val[2]), 32'd512);
`endif

      // Test 2: long stall inside frame 0 fills the buffer.
      do_reset();
      feed_off = 16'd0; feed_lim = 1536; feed_en = 1;
      c = 0;
      while (!(win_cnt >= 1 && midx >= 20) && c < 2000) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (c >= 2000) check("t2_timeout_start", 32'(midx), 32'd20);
      audio_rdy = 1'b0;
      repeat (5) @(negedge clk);
      held = audio_out;
      check("t2_stall_valid_start", 32'(audio_valid), 32'd1);
      repeat (595) @(negedge clk);
      check("t2_stall_hold", 32'(audio_out), 32'(held));
      check("t2_stall_valid_end", 32'(audio_valid), 32'd1);
      check("t2_stall_sample_rdy", 32'(sample_rdy), 32'd0);
      check("t2_stall_occupancy", in_cnt, 1024);
      run_until_frames(5, 8000, 0);
      repeat (3) @(negedge clk);
      check("t2_frame_idx", 32'(frame_idx), 32'd5);

      // Test 3: values wrap mod 2^16 and frames straddle the buffer end.
      do_reset();
      feed_off = 16'd65000; feed_lim = 1536; feed_en = 1;
      run_until_frames(5, 12000, 1);
      repeat (3) @(negedge clk);
      check("t3_frame_idx", 32'(frame_idx), 32'd5);
`ifndef SIG_PREEMPH_EN
      check("t3_frame0_first", 32'(first_val[0]), 32'd65000);
      check("t3_frame3_first", 32'(first_val[3]), 32'd232);
      check("t3_frame4_first", 32'(first_val[4]), 32'd488);
`endif

      // Test 4: restart at sample 100 of frame 1.
      do_reset();
      feed_off = 16'd0; feed_lim = 100000; feed_en = 1;
      c = 0;
      while (!(exp_fidx == 1 && midx == 100) && c < 4000) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (c >= 4000) check("t4_timeout_start", midx, 100);
      restart = 1'b1;
      feed_lim = 0;
      @(posedge clk);
      #1;
      restart = 1'b0;
      @(negedge clk);
      check("t4_restart_valid", 32'(audio_valid), 32'd0);
      check("t4_restart_frame_idx", 32'(frame_idx), 32'd0);
      @(posedge clk);
      #1;
      feed_lim = feed_next + 511;
      c = 0;
      while (in_cnt < 511 && c < 1000) begin
         @(negedge clk);
         c++;
      end
      repeat (20) @(negedge clk);
      check("t4_no_early_init", win_cnt, 0);
      check("t4_samples_511", in_cnt, 511);
      @(posedge clk);
      #1;
      feed_lim = feed_lim + 1;
      run_until_frames(1, 3000, 0);
      repeat (3) @(negedge clk);
      check("t4_frame_idx", 32'(frame_idx), 32'd1);

`ifdef SIG_PREEMPH_EN
      // Test 6: pre-emphasis arithmetic and saturation.
      begin
         logic signed [15:0] tbl [4];
         tbl = '{16'sd1000, 16'sd1000, -16'sd32768, 16'sd32767};
         do_reset();
         for (int i = 0; i < FL; i++) begin
            @(posedge clk);
            #1;
            sample_valid = 1'b1;
            sample_in    = (i < 4) ? tbl[i] : 16'sd0;
         end
         @(posedge clk);
         #1;
         sample_valid = 1'b0;
         run_until_frames(1, 3000, 0);
         check("pe_first", 32'(cap[0]), 32'd1000);
         check("pe_second", 32'(cap[1]), 32'd30);
         check("pe_neg_full", 32'(cap[2]), 32'h8000);
         check("pe_saturate", 32'(cap[3]), 32'h7FFF);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
